// File: rtl/network_pkg.sv
// Shared state encoding and default parameters for the conv-network pass sequencer.
package network_pkg;

  localparam int unsigned DEF_NUM_LAYERS = 4;
  localparam int unsigned DEF_CW         = 32;
  localparam int unsigned DEF_TIMEOUT    = 1024;
  localparam logic [15:0] OVERRUN_MAX    = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_START,
    ST_WAIT,
    ST_CACHE,
    ST_OUTPUT
  } seq_state_t;

endpackage

// File: rtl/rising_edge_detect.sv
// Registered rising-edge detector; prev resets high so a level already high at
// reset release is not mistaken for an edge.
module rising_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b1;
    else     prev <= din;
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/network_sequencer.sv
// Sequences one pass of NUM_LAYERS conv layers per audio sample edge and keeps
// latency / overrun / timeout statistics.
module network_sequencer
  import network_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int unsigned CW         = DEF_CW,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_clk,
  input  logic                  enable,
  input  logic                  clr_stats,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic                  lsb_strobe,
  output logic [NUM_LAYERS-1:0] layer_start,
  output logic [NUM_LAYERS-2:0] cache_strobe,
  output logic                  out_strobe,
  output logic                  busy,
  output logic [15:0]           overrun_count,
  output logic                  timeout_err,
  output logic [CW-1:0]         last_latency,
  output logic [CW-1:0]         max_latency
);

  localparam int unsigned IW = $clog2(NUM_LAYERS);
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_LAYERS - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  seq_state_t    state, state_next;
  logic [IW-1:0] idx;
  logic [TW-1:0] timer;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] pass_cnt_inc;
  logic          sample_rise;
  logic          cur_done;
  logic          wait_expired;

  rising_edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (sample_clk),
    .rise (sample_rise)
  );

  assign cur_done     = layer_done[idx];
  assign wait_expired = (state == ST_WAIT) && !cur_done && (timer == TIMER_LAST);
  assign pass_cnt_inc = (pass_cnt == '1) ? pass_cnt : pass_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    lsb_strobe   = 1'b0;
    out_strobe   = 1'b0;
    busy         = (state != ST_IDLE);
    layer_start  = '0;
    cache_strobe = '0;

    unique case (state)
      ST_IDLE:   if (sample_rise && enable) state_next = ST_SHIFT;
      ST_SHIFT:  state_next = ST_START;
      ST_START:  state_next = ST_WAIT;
      ST_WAIT: begin
        if (cur_done)          state_next = (idx == LAST_IDX) ? ST_OUTPUT : ST_CACHE;
        else if (wait_expired) state_next = ST_IDLE;
      end
      ST_CACHE:  state_next = ST_START;
      ST_OUTPUT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase

    lsb_strobe = (state == ST_SHIFT);
    out_strobe = (state == ST_OUTPUT);
    for (int unsigned i = 0; i < NUM_LAYERS; i++)
      layer_start[i] = (state == ST_START) && (idx == IW'(i));
    for (int unsigned i = 0; i < NUM_LAYERS - 1; i++)
      cache_strobe[i] = (state == ST_CACHE) && (idx == IW'(i));
  end

  // pass_cnt holds the cycles already spent in the pass, so OUTPUT reports pass_cnt+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      timer    <= '0;
      pass_cnt <= '0;
    end else begin
      unique case (state)
        ST_SHIFT: begin
          idx      <= '0;
          pass_cnt <= CW'(1);
        end
        ST_START: begin
          timer    <= '0;
          pass_cnt <= pass_cnt_inc;
        end
        ST_WAIT: begin
          if (!cur_done && !wait_expired) timer <= timer + 1'b1;
          pass_cnt <= pass_cnt_inc;
        end
        ST_CACHE: begin
          idx      <= idx + 1'b1;
          pass_cnt <= pass_cnt_inc;
        end
        ST_OUTPUT: pass_cnt <= pass_cnt_inc;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_count <= '0;
      timeout_err   <= 1'b0;
      last_latency  <= '0;
      max_latency   <= '0;
    end else begin
      if (state == ST_OUTPUT) last_latency <= pass_cnt_inc;

      if (clr_stats) begin
        overrun_count <= '0;
        timeout_err   <= 1'b0;
        max_latency   <= '0;
      end else begin
        if (sample_rise && (state != ST_IDLE) && (overrun_count != OVERRUN_MAX))
          overrun_count <= overrun_count + 1'b1;
        if (wait_expired)
          timeout_err <= 1'b1;
        if ((state == ST_OUTPUT) && (pass_cnt_inc > max_latency))
          max_latency <= pass_cnt_inc;
      end
    end
  end

endmodule
